mips_multicycle: RTL and testbench

//  Multi-cycle MIPS-I subset core, successor to the single-cycle top. Shares one memory port for fetch and data.
//  The port uses a req/ack handshake, so memories with wait states are supported.

---
 rtl/mips_multicycle.sv | 231 +++++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I subset core with one shared req/ack memory port for fetch and data,
// FSM control, a bus watchdog and sticky fault reporting.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter bit          HALT_ON_ERROR  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        retired,
  output logic        halted,
  output logic [1:0]  error,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;
  localparam logic [1:0] E_NONE = 2'b00, E_ILLEGAL = 2'b01, E_TIMEOUT = 2'b10, E_MISALIGN = 2'b11;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] pc, ir, mdr, alu_out;
  logic [7:0]  wd_cnt;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, imm_se, pc_plus4, br_target, jump_target, mem_ea, alu_result;
  logic        legal, is_jr, is_mem_op, wait_cycle, timed_out;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign shamt       = ir[10:6];
  assign funct       = ir[5:0];
  assign rs_val      = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val      = (rt == 5'd0) ? '0 : regs[rt];
  assign imm_se      = {{16{ir[15]}}, ir[15:0]};
  assign pc_plus4    = pc + 32'd4;
  assign br_target   = pc_plus4 + {imm_se[29:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], ir[25:0], 2'b00};
  assign mem_ea      = rs_val + imm_se;
  assign is_jr       = (op == OP_RTYPE) && (funct == F_JR);
  assign is_mem_op   = (op == OP_LW) || (op == OP_SW);
  assign wait_cycle  = mem_req && !mem_ack;
  assign timed_out   = wait_cycle && (wd_cnt == WD_LAST);
  assign pc_out      = pc;

  always_comb begin
    legal      = 1'b0;
    alu_result = '0;
    case (op)
      OP_RTYPE: begin
        legal = funct inside {F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        case (funct)
          F_ADD:   alu_result = rs_val + rt_val;
          F_SUB:   alu_result = rs_val - rt_val;
          F_AND:   alu_result = rs_val & rt_val;
          F_OR:    alu_result = rs_val | rt_val;
          F_SLT:   alu_result = {31'b0, $signed(rs_val) < $signed(rt_val)};
          F_SLL:   alu_result = rt_val << shamt;
          F_SRL:   alu_result = rt_val >> shamt;
          default: alu_result = '0;
        endcase
      end
      OP_ADDI:                                  begin legal = 1'b1; alu_result = rs_val + imm_se; end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
  end

  // Per-state decisions: fault code, whether to start the next fetch (and from where), retire.
  logic [1:0]  fault;
  logic        go_fetch, do_retire, rf_we;
  logic [31:0] npc, rf_wdata;
  logic [4:0]  rf_waddr;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    fault     = E_NONE;
    go_fetch  = 1'b0;
    do_retire = 1'b0;
    npc       = pc_plus4;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_out;
    case (state)
      S_FETCH: if (timed_out) fault = E_TIMEOUT;
      S_DECODE: begin
        if (!legal) fault = E_ILLEGAL;
        else if (op == OP_J || op == OP_JAL) begin
          go_fetch  = 1'b1;
          do_retire = 1'b1;
          npc       = jump_target;
          if (op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_plus4;
          end
        end else if (is_jr) begin
          if (rs_val[1:0] != 2'b00) fault = E_MISALIGN;
          else begin
            go_fetch  = 1'b1;
            do_retire = 1'b1;
            npc       = rs_val;
          end
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ || op == OP_BNE) begin
          go_fetch  = 1'b1;
          do_retire = 1'b1;
          npc       = ((rs_val == rt_val) == (op == OP_BEQ)) ? br_target : pc_plus4;
        end else if (is_mem_op && mem_ea[1:0] != 2'b00) fault = E_MISALIGN;
      end
      S_MEM: begin
        if (timed_out) fault = E_TIMEOUT;
        else if (mem_req && mem_ack && op == OP_SW) begin
          go_fetch  = 1'b1;
          do_retire = 1'b1;
        end
      end
      S_WB: begin
        go_fetch  = 1'b1;
        do_retire = 1'b1;
        rf_we     = 1'b1;
        rf_waddr  = (op == OP_RTYPE) ? rd : rt;
        rf_wdata  = (op == OP_LW) ? mdr : alu_out;
      end
      default: ;
    endcase
    // Skip-on-fault mode: drop the faulting instruction and fetch the next one, no retire.
    if (fault != E_NONE && !HALT_ON_ERROR) begin
      go_fetch = 1'b1;
      npc      = pc_plus4;
    end
  end

  // NOTE: the register file has no reset; it maps onto RAM and software initialises it.
  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so later lines in this block
  // override earlier ones for the same edge (go_fetch wins over the fault-time mem_req drop).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retired   <= 1'b0;
      halted    <= 1'b0;
      error     <= E_NONE;
      ir        <= '0;
      mdr       <= '0;
      alu_out   <= '0;
      wd_cnt    <= '0;
    end else begin
      retired <= do_retire;
      if (wait_cycle) wd_cnt <= wd_cnt + 8'd1;
      if (fault != E_NONE) begin
        mem_req <= 1'b0;
        if (error == E_NONE) error <= fault;
        if (HALT_ON_ERROR) begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      end
      if (go_fetch) begin
        state    <= S_FETCH;
        pc       <= npc;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= npc;
        wd_cnt   <= '0;
      end else if (fault == E_NONE) begin
        case (state)
          S_FETCH: begin
            if (!mem_req) begin
              // First fetch after reset: the request is issued from the reset PC.
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              wd_cnt   <= '0;
            end else if (mem_ack) begin
              ir      <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_DECODE;
            end
          end
          S_DECODE: state <= S_EXEC;
          S_EXEC: begin
            alu_out <= alu_result;
            if (is_mem_op) begin
              mem_req   <= 1'b1;
              mem_we    <= (op == OP_SW);
              mem_addr  <= mem_ea;
              mem_wdata <= rt_val;
              wd_cnt    <= '0;
              state     <= S_MEM;
            end else state <= S_WB;
          end
          S_MEM: begin
            if (mem_req && mem_ack) begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= S_WB;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: directed latency/fault scenarios plus a random program checked
// against an instruction-level reference model with random memory wait states.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, retired, halted;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  error;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16), .HALT_ON_ERROR(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .retired(retired),
    .halted(halted), .error(error), .pc_out(pc_out)
  );

  logic [31:0] mem   [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int fetch_wait = 0, data_wait = 0;
  bit rand_wait = 0, never_ack = 0;
  logic [31:0] hang_addr = 32'hffff_ffff, watch_addr = 32'hffff_ffff;
  int req_cycles = 0, watch_cnt = 0, data_req_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (!reset && mem_req && mem_ack && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  // Memory responder: ack is set up on the falling edge and consumed at the next rising edge.
  bit busy = 0;
  int wcnt = 0, wtarget = 0;
  always @(negedge clk) begin
    if (mem_ack) begin mem_ack = 1'b0; busy = 0; end
    if (reset || !mem_req) busy = 0;
    else begin
      if (!busy) begin
        busy = 1; wcnt = 0;
        wtarget = rand_wait ? int'($urandom_range(0, 2)) : (mem_addr >= 32'h200 ? data_wait : fetch_wait);
      end
      if (!never_ack && mem_addr != hang_addr && wcnt >= wtarget) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
      end else wcnt++;
    end
    if (mem_req) req_cycles++;
    if (mem_req && mem_addr == watch_addr) watch_cnt++;
    if (mem_req && mem_addr >= 32'h200) data_req_cycles++;
  end

  function automatic logic [31:0] enc_r(int f, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int idx);
    return {6'(op), 26'(idx)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    mem[addr >> 2] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    req_cycles = 0; watch_cnt = 0; data_req_cycles = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_retire(output int at);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (retired === 1'b1) begin at = cyc; return; end
    end
    at = -1;
    check("retire_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Instruction-level reference: one call executes one whole instruction.
  task automatic model_step();
    logic [31:0] ins, a, b, se, npc, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    ins = m_mem[m_pc[11:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    a = m_reg[rs]; b = m_reg[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ea = a + se;
    npc = m_pc + 4;
    case (op)
      6'h00: case (fn)
        6'h20: m_reg[rd] = a + b;
        6'h22: m_reg[rd] = a - b;
        6'h24: m_reg[rd] = a & b;
        6'h25: m_reg[rd] = a | b;
        6'h2a: m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: m_reg[rd] = b << sh;
        6'h02: m_reg[rd] = b >> sh;
        6'h08: npc = a;
        default: ;
      endcase
      6'h08: m_reg[rt] = a + se;
      6'h23: m_reg[rt] = m_mem[ea[11:2]];
      6'h2b: m_mem[ea[11:2]] = b;
      6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
      6'h05: if (a != b) npc = m_pc + 4 + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin m_reg[31] = m_pc + 4; npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    m_reg[0] = '0;
    m_pc = npc;
  endtask

  initial begin
    int t[8];
    logic [31:0] v;
    int pc, loop_addr, guard;
    int exp_gap1[6] = '{4, 4, 3, 4, 3, 3};
    logic [31:0] exp_pc1[7] = '{32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h14, 32'h14};

    // Reset values and test 1: addi/addi/add, untaken bne, store, beq self-loop.
    clear_mem();
    put(32'h00, enc_i(8, 0, 1, 5));
    put(32'h04, enc_i(8, 0, 2, 7));
    put(32'h08, enc_r(32'h20, 1, 2, 3, 0));
    put(32'h0c, enc_i(5, 1, 1, 5));
    put(32'h10, enc_i(32'h2b, 0, 3, 32'h200));
    put(32'h14, enc_i(4, 1, 1, -1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wait_retire(t[i]);
      check("t1_pc", pc_out, exp_pc1[i]);
    end
    for (int i = 1; i < 7; i++) check("t1_gap", 32'(t[i] - t[i-1]), 32'(exp_gap1[i-1]));
    check("t1_r3", mem[32'h200 >> 2], 32'd12);

    // Test 2: lw with three data wait states; address held for four request cycles.
    clear_mem();
    v = $urandom;
    put(32'h00, enc_i(8, 0, 5, 1));
    put(32'h04, enc_i(32'h23, 0, 4, 32'h204));
    put(32'h08, enc_i(32'h2b, 0, 4, 32'h208));
    put(32'h0c, enc_i(4, 0, 0, -1));
    put(32'h204, v);
    data_wait = 3; watch_addr = 32'h204;
    do_reset();
    for (int i = 0; i < 3; i++) wait_retire(t[i]);
    check("t2_lw_gap", 32'(t[1] - t[0]), 32'd8);
    check("t2_sw_gap", 32'(t[2] - t[1]), 32'd7);
    check("t2_addr_hold", 32'(watch_cnt), 32'd4);
    check("t2_rt_data", mem[32'h208 >> 2], v);
    data_wait = 0; watch_addr = 32'hffff_ffff;

    // Test 4: j to 0x100, jal to 0x140 (r31=0x104), store r31, jr r31 back to 0x104.
    clear_mem();
    put(32'h000, enc_j(2, 32'h40));
    put(32'h100, enc_j(3, 32'h50));
    put(32'h104, enc_i(4, 0, 0, -1));
    put(32'h140, enc_i(32'h2b, 0, 31, 32'h200));
    put(32'h144, enc_r(8, 31, 0, 0, 0));
    do_reset();
    for (int i = 0; i < 5; i++) wait_retire(t[i]);
    check("t4_j_pc", 32'(t[0] >= 0 ? 32'h100 : 0), 32'h100);
    check("t4_jal_gap", 32'(t[1] - t[0]), 32'd2);
    check("t4_sw_gap", 32'(t[2] - t[1]), 32'd4);
    check("t4_jr_gap", 32'(t[3] - t[2]), 32'd2);
    check("t4_loop_gap", 32'(t[4] - t[3]), 32'd3);
    check("t4_final_pc", pc_out, 32'h104);
    check("t4_r31", mem[32'h200 >> 2], 32'h104);

    // Test 5: ack never returns -> request held 16 cycles, timeout fault, halt.
    never_ack = 1;
    do_reset();
    wait_halt();
    check("t5_req_cycles", 32'(req_cycles), 32'd16);
    check("t5_error", 32'(error), 32'b10);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_req_low", 32'(mem_req), 32'd0);
    never_ack = 0;

    // Test 6: misaligned lw, then illegal opcode, then async reset during a fetch.
    clear_mem();
    put(32'h00, enc_i(32'h23, 0, 1, 32'h202));
    do_reset();
    wait_halt();
    check("t6_mis_error", 32'(error), 32'b11);
    check("t6_mis_noreq", 32'(data_req_cycles), 32'd0);
    check("t6_mis_halted", 32'(halted), 32'd1);
    put(32'h00, 32'hfc00_0000);
    do_reset();
    wait_halt();
    check("t6_ill_error", 32'(error), 32'b01);
    put(32'h00, enc_j(2, 32'h40));
    hang_addr = 32'h100;
    do_reset();
    wait_retire(t[0]);
    repeat (3) @(negedge clk);
    check("t6_mid_req", 32'(mem_req), 32'd1);
    check("t6_mid_pc", pc_out, 32'h100);
    #2 reset = 1'b1;
    #1;
    check("t6_arst_req", 32'(mem_req), 32'd0);
    check("t6_arst_pc", pc_out, 32'd0);
    hang_addr = 32'hffff_ffff;

    // Random program: seed all registers, random body, dump registers, self-loop.
    clear_mem();
    for (int w = 128; w < 256; w++) mem[w] = $urandom;
    pc = 0;
    for (int r = 1; r < 32; r++) begin put(pc, enc_i(8, 0, r, int'($urandom_range(0, 65535)))); pc += 4; end
    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          int fs[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a};
          put(pc, enc_r(fs[$urandom_range(0, 4)], $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), 0));
        end
        4: put(pc, enc_r($urandom_range(0, 1) * 2, 0, $urandom_range(0, 31), $urandom_range(1, 31),
                         $urandom_range(0, 31)));
        5: put(pc, enc_i(8, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535)));
        6: put(pc, enc_i(32'h23, 0, $urandom_range(0, 31), 32'h200 + 4 * $urandom_range(0, 63)));
        7: put(pc, enc_i(32'h2b, 0, $urandom_range(0, 31), 32'h200 + 4 * $urandom_range(0, 63)));
        8: put(pc, enc_i(4 + $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 1)));
        default: put(pc, enc_j(2 + $urandom_range(0, 1), (pc + 8) >> 2));
      endcase
      pc += 4;
    end
    for (int r = 1; r < 32; r++) begin put(pc, enc_i(32'h2b, 0, r, 32'h300 + 4 * r)); pc += 4; end
    loop_addr = pc;
    put(pc, enc_i(4, 0, 0, -1));
    for (int w = 0; w < 1024; w++) m_mem[w] = mem[w];
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_pc = '0;
    rand_wait = 1;
    do_reset();
    guard = 0;
    while (m_pc != 32'(loop_addr) && guard < 400) begin
      guard++;
      wait_retire(t[0]);
      if (t[0] < 0) break;
      model_step();
      check("rand_pc", pc_out, m_pc);
    end
    repeat (4) @(negedge clk);
    for (int w = 128; w < 256; w++) check("rand_mem", mem[w], m_mem[w]);
    check("rand_halted", 32'(halted), 32'd0);
    check("rand_error", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
